// File: rtl/cell_char_pkg.sv
// Shared types and constants for the 3-input cell characterisation driver.
package cell_char_pkg;

    localparam int unsigned NVEC  = 8;
    localparam int unsigned VEC_W = 3;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned TOG_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    // Single-input-toggle order, including the 100 -> 000 wrap.
    localparam logic [VEC_W-1:0] GRAY3_SEQ [NVEC] = '{
        3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100
    };

    localparam logic [NVEC-1:0] NOR3_TT  = 8'h01;
    localparam logic [NVEC-1:0] NAND3_TT = 8'h7F;
    localparam logic [NVEC-1:0] AND3_TT  = 8'h80;
    localparam logic [NVEC-1:0] OR3_TT   = 8'hFE;

endpackage

// File: rtl/cell3_char_driver_if.sv
// Run-control, cell-pin and result signals between controller/cell and driver.
interface cell3_char_driver_if;
    import cell_char_pkg::*;

    logic               START;
    logic               IN1;
    logic               IN2;
    logic               IN3;
    logic               QN;
    logic               BUSY;
    logic               DONE;
    logic [ERR_W-1:0]   ERR_CNT;
    logic [TOG_W-1:0]   TOGGLE_CNT;
    logic               FAIL_VLD;
    logic [VEC_W-1:0]   FAIL_VEC;

    modport master (
        output START, QN,
        input  IN1, IN2, IN3, BUSY, DONE, ERR_CNT, TOGGLE_CNT, FAIL_VLD, FAIL_VEC
    );

    modport slave (
        input  START, QN,
        output IN1, IN2, IN3, BUSY, DONE, ERR_CNT, TOGGLE_CNT, FAIL_VLD, FAIL_VEC
    );

endinterface

// File: rtl/gray3_seq.sv
// Vector index, settle and pass counters; flags the sample cycle and the final sample.
module gray3_seq
    import cell_char_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [VEC_W-1:0] vec_c,
    output logic [VEC_W-1:0] nxt_vec_c,
    output logic             sample_c,
    output logic             last_c
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned PW = $clog2(PASSES + 1);

    logic [VEC_W-1:0] idx;
    logic [SW-1:0]    settle;
    logic [PW-1:0]    pass;

    assign vec_c     = GRAY3_SEQ[idx];
    assign nxt_vec_c = GRAY3_SEQ[idx + VEC_W'(1)];
    assign sample_c  = en && (settle == SW'(SETTLE_CYCLES));
    assign last_c    = sample_c && (idx == VEC_W'(NVEC - 1)) && (pass == PW'(PASSES - 1));

    // A vector is held for SETTLE_CYCLES+1 cycles; sample on the last of them.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx    <= '0;
            settle <= '0;
            pass   <= '0;
        end else if (en) begin
            if (sample_c) begin
                settle <= '0;
                idx    <= idx + VEC_W'(1);
                if (idx == VEC_W'(NVEC - 1)) begin
                    pass <= pass + PW'(1);
                end
            end else begin
                settle <= settle + SW'(1);
            end
        end
    end

endmodule

// File: rtl/cell3_char_driver.sv
// Drives a 3-input cell through the Gray sequence, checks QN against TRUTH and counts QN toggles.
module cell3_char_driver
    import cell_char_pkg::*;
#(
    parameter logic [NVEC-1:0] TRUTH         = NOR3_TT,
    parameter int unsigned     SETTLE_CYCLES = 2,
    parameter int unsigned     PASSES        = 1
) (
    input  logic                CLK,
    input  logic                RST,
    cell3_char_driver_if.slave  bus
);

    state_t           state;
    logic             first_smp;
    logic             prev_qn;
    logic [VEC_W-1:0] vec_c;
    logic [VEC_W-1:0] nxt_vec_c;
    logic             sample_c;
    logic             last_c;
    logic             accept_c;
    logic             mismatch_c;
    logic             toggled_c;

    assign accept_c   = (state == ST_IDLE) && bus.START;
    // X/Z on QN must register as a failure, hence the case inequality.
    assign mismatch_c = (bus.QN !== TRUTH[vec_c]);
    assign toggled_c  = !first_smp && (bus.QN !== prev_qn);

    gray3_seq #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .PASSES        (PASSES)
    ) u_seq (
        .clk       (CLK),
        .rst       (RST),
        .clr       (accept_c),
        .en        (state == ST_RUN),
        .vec_c     (vec_c),
        .nxt_vec_c (nxt_vec_c),
        .sample_c  (sample_c),
        .last_c    (last_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state                      <= ST_IDLE;
            {bus.IN1, bus.IN2, bus.IN3} <= '0;
            bus.BUSY                   <= 1'b0;
            bus.DONE                   <= 1'b0;
            bus.ERR_CNT                <= '0;
            bus.TOGGLE_CNT             <= '0;
            bus.FAIL_VLD               <= 1'b0;
            bus.FAIL_VEC               <= '0;
            first_smp                  <= 1'b1;
            prev_qn                    <= 1'b0;
        end else begin
            bus.DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.START) begin
                        state                      <= ST_RUN;
                        bus.BUSY                   <= 1'b1;
                        {bus.IN1, bus.IN2, bus.IN3} <= GRAY3_SEQ[0];
                        bus.ERR_CNT                <= '0;
                        bus.TOGGLE_CNT             <= '0;
                        bus.FAIL_VLD               <= 1'b0;
                        bus.FAIL_VEC               <= '0;
                        first_smp                  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (sample_c) begin
                        first_smp <= 1'b0;
                        prev_qn   <= bus.QN;
                        if (mismatch_c) begin
                            if (bus.ERR_CNT != '1) begin
                                bus.ERR_CNT <= bus.ERR_CNT + ERR_W'(1);
                            end
                            if (!bus.FAIL_VLD) begin
                                bus.FAIL_VLD <= 1'b1;
                                bus.FAIL_VEC <= vec_c;
                            end
                        end
                        if (toggled_c && (bus.TOGGLE_CNT != '1)) begin
                            bus.TOGGLE_CNT <= bus.TOGGLE_CNT + TOG_W'(1);
                        end
                        if (last_c) begin
                            state                      <= ST_FIN;
                            bus.BUSY                   <= 1'b0;
                            bus.DONE                   <= 1'b1;
                            {bus.IN1, bus.IN2, bus.IN3} <= '0;
                        end else begin
                            {bus.IN1, bus.IN2, bus.IN3} <= nxt_vec_c;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell3_char_driver.sv
// Scoreboard bench: four driver instances (default, two passes, NAND3 table, stuck-at-0 QN).
module tb_cell3_char_driver;
    import cell_char_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    int   cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    cell3_char_driver_if if0 ();
    cell3_char_driver_if if1 ();
    cell3_char_driver_if if2 ();
    cell3_char_driver_if if3 ();

    cell3_char_driver #(.TRUTH(NOR3_TT),  .SETTLE_CYCLES(2), .PASSES(1)) u_def  (.CLK(CLK), .RST(RST), .bus(if0));
    cell3_char_driver #(.TRUTH(NOR3_TT),  .SETTLE_CYCLES(2), .PASSES(2)) u_p2   (.CLK(CLK), .RST(RST), .bus(if1));
    cell3_char_driver #(.TRUTH(NAND3_TT), .SETTLE_CYCLES(2), .PASSES(1)) u_nand (.CLK(CLK), .RST(RST), .bus(if2));
    cell3_char_driver #(.TRUTH(NOR3_TT),  .SETTLE_CYCLES(2), .PASSES(3)) u_stk  (.CLK(CLK), .RST(RST), .bus(if3));

    logic        start_w [4];
    logic        done_w  [4];
    logic        busy_w  [4];
    logic        fvld_w  [4];
    logic [2:0]  in_w    [4];
    logic [2:0]  fvec_w  [4];
    logic [7:0]  err_w   [4];
    logic [15:0] tog_w   [4];

    // NOR3X1 models on the first three, stuck-at-0 output on the fourth.
    assign if0.QN = ~(if0.IN1 | if0.IN2 | if0.IN3);
    assign if1.QN = ~(if1.IN1 | if1.IN2 | if1.IN3);
    assign if2.QN = ~(if2.IN1 | if2.IN2 | if2.IN3);
    assign if3.QN = 1'b0;

    assign if0.START = start_w[0];
    assign if1.START = start_w[1];
    assign if2.START = start_w[2];
    assign if3.START = start_w[3];

    assign done_w[0] = if0.DONE; assign busy_w[0] = if0.BUSY; assign fvld_w[0] = if0.FAIL_VLD; assign fvec_w[0] = if0.FAIL_VEC;
    assign done_w[1] = if1.DONE; assign busy_w[1] = if1.BUSY; assign fvld_w[1] = if1.FAIL_VLD; assign fvec_w[1] = if1.FAIL_VEC;
    assign done_w[2] = if2.DONE; assign busy_w[2] = if2.BUSY; assign fvld_w[2] = if2.FAIL_VLD; assign fvec_w[2] = if2.FAIL_VEC;
    assign done_w[3] = if3.DONE; assign busy_w[3] = if3.BUSY; assign fvld_w[3] = if3.FAIL_VLD; assign fvec_w[3] = if3.FAIL_VEC;
    assign in_w[0] = {if0.IN1, if0.IN2, if0.IN3}; assign err_w[0] = if0.ERR_CNT; assign tog_w[0] = if0.TOGGLE_CNT;
    assign in_w[1] = {if1.IN1, if1.IN2, if1.IN3}; assign err_w[1] = if1.ERR_CNT; assign tog_w[1] = if1.TOGGLE_CNT;
    assign in_w[2] = {if2.IN1, if2.IN2, if2.IN3}; assign err_w[2] = if2.ERR_CNT; assign tog_w[2] = if2.TOGGLE_CNT;
    assign in_w[3] = {if3.IN1, if3.IN2, if3.IN3}; assign err_w[3] = if3.ERR_CNT; assign tog_w[3] = if3.TOGGLE_CNT;

    typedef struct {
        int          sel;
        logic [7:0]  err;
        logic [15:0] tog;
        logic        fvld;
        logic [2:0]  fvec;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int sel, input logic [7:0] err, input logic [15:0] tog,
                            input logic fvld, input logic [2:0] fvec, input int done_cyc);
        exp_t e;
        e.sel = sel; e.err = err; e.tog = tog; e.fvld = fvld; e.fvec = fvec; e.done_cyc = done_cyc;
        sb.push_back(e);
    endtask

    task automatic pulse_start(input int sel);
        start_w[sel] = 1'b1;
        @(negedge CLK);
        start_w[sel] = 1'b0;
    endtask

    // Wait for DONE on the expected instance, optionally checking the Gray order on the pins.
    task automatic await_result(input bit chk_seq);
        exp_t e;
        int   guard;
        int   rel;
        logic [2:0] gexp;
        e = sb.pop_front();
        guard = 0;
        while (!done_w[e.sel] && guard < 300) begin
            rel = cyc - (e.done_cyc - 25);
            if (chk_seq && rel >= 1 && rel <= 22 && ((rel - 1) % 3) == 0) begin
                gexp = GRAY3_SEQ[(rel - 1) / 3];
                check($sformatf("gray_vec%0d", (rel - 1) / 3), 32'(in_w[e.sel]), 32'(gexp));
            end
            @(negedge CLK);
            guard++;
        end
        if (!done_w[e.sel]) begin
            check("done_timeout", 32'd0, 32'd1);
            return;
        end
        check($sformatf("done_cyc_s%0d", e.sel), 32'(cyc), 32'(e.done_cyc));
        check($sformatf("err_s%0d", e.sel),  32'(err_w[e.sel]),  32'(e.err));
        check($sformatf("tog_s%0d", e.sel),  32'(tog_w[e.sel]),  32'(e.tog));
        check($sformatf("fvld_s%0d", e.sel), 32'(fvld_w[e.sel]), 32'(e.fvld));
        check($sformatf("fvec_s%0d", e.sel), 32'(fvec_w[e.sel]), 32'(e.fvec));
        check($sformatf("busy_at_done_s%0d", e.sel), 32'(busy_w[e.sel]), 32'd0);
        check($sformatf("in_at_done_s%0d", e.sel),   32'(in_w[e.sel]),   32'd0);
        @(negedge CLK);
        check($sformatf("done_pulse_s%0d", e.sel), 32'(done_w[e.sel]), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) start_w[i] = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(busy_w[0]), 32'd0);
        check("rst_done", 32'(done_w[0]), 32'd0);
        check("rst_in",   32'(in_w[0]),   32'd0);
        check("rst_err",  32'(err_w[0]),  32'd0);
        check("rst_tog",  32'(tog_w[0]),  32'd0);
        check("rst_fvld", 32'(fvld_w[0]), 32'd0);
        check("rst_fvec", 32'(fvec_w[0]), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Default NOR3 run
        push_exp(0, 8'd0, 16'd1, 1'b0, 3'b000, cyc + 25);
        pulse_start(0);
        check("busy_cycle1", 32'(busy_w[0]), 32'd1);
        await_result(1'b1);

        // Two passes: wrap sample 0 -> 1 counts
        push_exp(1, 8'd0, 16'd3, 1'b0, 3'b000, cyc + 49);
        pulse_start(1);
        await_result(1'b0);

        // NAND3 table against NOR3 cell
        push_exp(2, 8'd6, 16'd1, 1'b1, 3'b001, cyc + 25);
        pulse_start(2);
        await_result(1'b0);

        // QN stuck at 0, three passes
        push_exp(3, 8'd3, 16'd0, 1'b1, 3'b000, cyc + 73);
        pulse_start(3);
        await_result(1'b0);

        // Reset mid-run at cycle 10
        pulse_start(0);
        repeat (9) @(negedge CLK);
        check("tog_before_rst", 32'(tog_w[0]), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_busy", 32'(busy_w[0]), 32'd0);
        check("midrst_in",   32'(in_w[0]),   32'd0);
        check("midrst_tog",  32'(tog_w[0]),  32'd0);
        check("midrst_err",  32'(err_w[0]),  32'd0);
        check("midrst_fvld", 32'(fvld_w[0]), 32'd0);
        @(negedge CLK);
        check("midrst_idle", 32'(busy_w[0]), 32'd0);
        push_exp(0, 8'd0, 16'd1, 1'b0, 3'b000, cyc + 25);
        pulse_start(0);
        await_result(1'b0);

        // START held for 40 cycles: one run, then a second from cycle 26
        n = cyc;
        push_exp(0, 8'd0, 16'd1, 1'b0, 3'b000, n + 25);
        push_exp(0, 8'd0, 16'd1, 1'b0, 3'b000, n + 51);
        start_w[0] = 1'b1;
        @(negedge CLK);
        await_result(1'b0);
        @(negedge CLK);
        check("held_rerun_busy", 32'(busy_w[0]), 32'd1);
        check("held_clear_tog",  32'(tog_w[0]),  32'd0);
        while (cyc < n + 40) @(negedge CLK);
        start_w[0] = 1'b0;
        await_result(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/cell3_char_driver.md
# cell3_char_driver

Clocked stimulus driver and response checker for 3-input combinational library cells such as NOR3X1. It drives the cell's IN1/IN2/IN3 pins through a single-input-toggle (Gray) sequence and samples QN after a programmable settle time. It checks each sample against an 8-entry truth table and counts output toggles for power characterization. It sits in the power-test harness between the run controller and the cell under test.

## Interface
- `TRUTH`, default 8'h01: expected QN indexed by {IN1,IN2,IN3}. 8'h01 is NOR3.
- `SETTLE_CYCLES`, default 2 (min 1): cycles from vector apply to QN sample.
- `PASSES`, default 1 (min 1): number of full 8-vector sequences per run.
- `CLK`, in, 1: clock. Single clock domain.
- `RST`, in, 1: reset. Synchronous, active-high.
- `START`, in, 1: begin a run. Honoured only in IDLE.
- `IN1`, `IN2`, `IN3`, out, 1 each: registered drives to the cell.
- `QN`, in, 1: cell output, sampled on `CLK`.
- `BUSY`, out, 1: run in progress.
- `DONE`, out, 1: one-cycle pulse at end of run.
- `ERR_CNT`, out, 8: mismatch count, saturates at 255.
- `TOGGLE_CNT`, out, 16: QN changes between consecutive samples, saturating.
- `FAIL_VLD`, out, 1: at least one mismatch this run.
- `FAIL_VEC`, out, 3: {IN1,IN2,IN3} of the first mismatch.

## Operation
- FSM states:
  - IDLE: START=1 goes to RUN.
  - RUN: applies and samples vectors; after the final sample goes to FIN.
  - FIN: 1 cycle, then IDLE.
- Vector order (idx 0..7) = 000, 001, 011, 010, 110, 111, 101, 100. Exactly one input toggles per step, including the 100 to 000 wrap between passes.
- Sample compare:
  - Mismatch when QN !== TRUTH[vec]. An X or Z on QN counts as a mismatch.
  - On mismatch: ERR_CNT += 1 (saturating). On the first mismatch, set FAIL_VLD=1 and FAIL_VEC=vec.
- Toggle count:
  - Each sample after the first in a run is compared with the previous sample; a difference increments TOGGLE_CNT.
  - The first sample of a run has no predecessor and never counts.
  - Pass-to-pass wrap samples do count.
- START accepted in IDLE clears ERR_CNT, TOGGLE_CNT, FAIL_VLD and FAIL_VEC on the same edge.
- Results hold after DONE until the next accepted START.
- START while BUSY or in FIN is ignored.
- RST, at any time including mid-run:
  - State goes to IDLE.
  - IN1..IN3=0, BUSY=0, DONE=0.
  - ERR_CNT=0, TOGGLE_CNT=0, FAIL_VLD=0, FAIL_VEC=0.
  - RST overrides a coincident START.

## Timing
- Cycle 0: START high in IDLE.
- Cycle 1: BUSY=1, IN1..IN3 = vector 0.
- Vector period P = SETTLE_CYCLES+1.
  - Vector k is applied at cycle 1+k·P.
  - QN is sampled at cycle 1+k·P+SETTLE_CYCLES.
  - The next vector appears on the following cycle.
- Counters and FAIL_* update one cycle after their sample edge.
- Final sample is at cycle 8·PASSES·P.
- On the next cycle: BUSY=0, DONE=1, IN1..IN3 return to 000, and all results are final.
- Earliest next START is accepted one cycle after DONE.
- Run length in BUSY cycles = 8·PASSES·P. Defaults: 24.

## Structure
- Package `cell_char_pkg` holds:
  - the state enum;
  - the `GRAY3_SEQ[8]` constant;
  - truth-table constants `NOR3_TT`=8'h01, `NAND3_TT`=8'h7F, `AND3_TT`=8'h80, `OR3_TT`=8'hFE.
- Sub-module `gray3_seq` holds:
  - the 3-bit index counter;
  - the pass counter;
  - the settle counter;
  - outputs: vec, sample strobe, last flag.
- Top level holds the FSM, compare logic and counters.

## Test plan
- Real NOR3X1 attached, default parameters, START pulse:
  - DONE at cycle 25.
  - ERR_CNT=0, FAIL_VLD=0, TOGGLE_CNT=1.
  - IN pins show the Gray order with period 3.
- PASSES=2:
  - TOGGLE_CNT=3 (the wrap 0→1 counts).
  - ERR_CNT=0, DONE at cycle 49.
- TRUTH=NAND3_TT against NOR3X1:
  - ERR_CNT=6 per pass.
  - FAIL_VLD=1, FAIL_VEC=3'b001.
- QN stuck-at-0 model, PASSES=3:
  - ERR_CNT=3, FAIL_VEC=3'b000, TOGGLE_CNT=0.
- RST asserted at cycle 10 of a run:
  - Next cycle: BUSY=0, IN=000, all counters 0.
  - A later START produces the normal default result.
- START held high for 40 cycles:
  - Exactly one run (DONE once at 25), then a second run starts at cycle 26.
  - Results of the first run are cleared on that START.
